// File: rtl/caliptra_sync_debounce.sv
// Debounce filter for an already-synchronized single-bit level.
// Produces a qualified level, one-cycle edge pulses, and saturating rise/glitch counters.
module caliptra_sync_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  parameter bit          RST_VAL       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             din,
  input  logic             en,
  input  logic             cnt_clr,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] event_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int unsigned      SC_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STABLE_CYCLES - 1);
  localparam bit               ONE_SHOT = (STABLE_CYCLES == 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SC_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
  logic             inc_event, inc_glitch;

  // State and output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      if (RST_VAL) state_q <= STABLE_HI;
      else         state_q <= STABLE_LO;
      stab_cnt_q   <= '0;
      level_q      <= RST_VAL;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      event_cnt_q  <= '0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      stab_cnt_q   <= stab_cnt_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      event_cnt_q  <= event_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  // Next-state, qualification and pulse generation
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    inc_event  = 1'b0;
    inc_glitch = 1'b0;

    if (!en) begin
      // Disabling abandons any qualification silently
      if (level_q) state_d = STABLE_HI;
      else         state_d = STABLE_LO;
      stab_cnt_d = '0;
    end else begin
      case (state_q)
        STABLE_LO: begin
          if (din) begin
            if (ONE_SHOT) begin
              state_d   = STABLE_HI;
              level_d   = 1'b1;
              rise_d    = 1'b1;
              inc_event = 1'b1;
            end else begin
              state_d    = QUAL_HI;
              stab_cnt_d = SC_W'(1);
            end
          end
        end
        QUAL_HI: begin
          if (!din) begin
            state_d    = STABLE_LO;
            stab_cnt_d = '0;
            inc_glitch = 1'b1;
          end else if (stab_cnt_q == SC_LAST) begin
            state_d    = STABLE_HI;
            stab_cnt_d = '0;
            level_d    = 1'b1;
            rise_d     = 1'b1;
            inc_event  = 1'b1;
          end else begin
            stab_cnt_d = stab_cnt_q + SC_W'(1);
          end
        end
        STABLE_HI: begin
          if (!din) begin
            if (ONE_SHOT) begin
              state_d = STABLE_LO;
              level_d = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d    = QUAL_LO;
              stab_cnt_d = SC_W'(1);
            end
          end
        end
        QUAL_LO: begin
          if (din) begin
            state_d    = STABLE_HI;
            stab_cnt_d = '0;
            inc_glitch = 1'b1;
          end else if (stab_cnt_q == SC_LAST) begin
            state_d    = STABLE_LO;
            stab_cnt_d = '0;
            level_d    = 1'b0;
            fall_d     = 1'b1;
          end else begin
            stab_cnt_d = stab_cnt_q + SC_W'(1);
          end
        end
        default: begin
          state_d    = STABLE_LO;
          stab_cnt_d = '0;
        end
      endcase
    end

    // Saturating counters; clear wins over a coincident increment
    if (cnt_clr)                                event_cnt_d = '0;
    else if (inc_event && event_cnt_q != CNT_MAX) event_cnt_d = event_cnt_q + CNT_W'(1);
    else                                         event_cnt_d = event_cnt_q;

    if (cnt_clr)                                  glitch_cnt_d = '0;
    else if (inc_glitch && glitch_cnt_q != CNT_MAX) glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
    else                                           glitch_cnt_d = glitch_cnt_q;
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign event_cnt  = event_cnt_q;
  assign glitch_cnt = glitch_cnt_q;

  a_no_dual_pulse: assert property (@(posedge clk) disable iff (!rst_b)
    !(rise_q && fall_q));
  a_rise_level: assert property (@(posedge clk) disable iff (!rst_b)
    rise_q |-> (level_q && !$past(level_q)));
  a_stab_range: assert property (@(posedge clk) disable iff (!rst_b)
    32'(stab_cnt_q) < STABLE_CYCLES);
  a_din_known: assert property (@(posedge clk) disable iff (!rst_b)
    en |-> !$isunknown(din));

endmodule

// File: doc/caliptra_sync_debounce.md
Name: caliptra_sync_debounce

Overview:
- Consumes the single-bit output of the 2-flop synchronizer, in the same clock domain.
- Qualifies the level through a stability filter and produces a debounced level with one-cycle rise/fall pulses.
- Keeps saturating counters of rise events and rejected glitches.
- Sits between synchronized external strobes (GPIO, wake, error pins) and interrupt/status logic.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required to accept a new level. Legal range 1..255; 1 means accept on the first sample.
- CNT_W, 8: width of event_cnt and glitch_cnt.
- RST_VAL, 0: value of level_o and of the FSM's stable state at reset.

Ports:
- clk  input  1  block clock, same domain as the upstream synchronizer.
- rst_b  input  1  asynchronous, active-low reset.
- din  input  1  synchronized input level, driven from the synchronizer dout.
- en  input  1  filter enable.
- cnt_clr  input  1  synchronous clear of event_cnt and glitch_cnt.
- level_o  output  1  debounced level.
- rise_o  output  1  one-cycle pulse when level_o goes 0->1.
- fall_o  output  1  one-cycle pulse when level_o goes 1->0.
- event_cnt  output  CNT_W  count of accepted rising edges, saturating.
- glitch_cnt  output  CNT_W  count of aborted qualifications, saturating.

Behaviour:
- Reset (rst_b low, async):
  - level_o=RST_VAL, rise_o=0, fall_o=0, event_cnt=0, glitch_cnt=0.
  - FSM=STABLE_HI if RST_VAL else STABLE_LO; stab_cnt=0.
- All state is updated on posedge clk. All outputs are registered; nothing is combinational from din to an output.
- FSM states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
- STABLE_LO:
  - din=1 and STABLE_CYCLES=1 -> STABLE_HI; level_o<=1, rise_o<=1.
  - din=1 and STABLE_CYCLES>1 -> QUAL_HI; stab_cnt<=1.
  - din=0 -> stay.
- QUAL_HI:
  - din=0 -> STABLE_LO; stab_cnt<=0; glitch_cnt increments.
  - din=1 and stab_cnt==STABLE_CYCLES-1 -> STABLE_HI; level_o<=1, rise_o<=1; stab_cnt<=0.
  - otherwise stab_cnt increments.
- STABLE_HI and QUAL_LO mirror STABLE_LO and QUAL_HI with din inverted, fall_o in place of rise_o, and level_o<=0.
- Latency: level_o and the pulse are visible in the cycle after the edge that captures the STABLE_CYCLES-th consecutive new-level sample. For STABLE_CYCLES=4, din high at edges e0..e3 gives level_o=1 and rise_o=1 after e3.
- rise_o and fall_o are each high for exactly one cycle and are never high together.
- en=0:
  - FSM forced to the STABLE state matching the current level_o; stab_cnt<=0.
  - level_o holds; rise_o=fall_o=0; counters hold.
  - Dropping en while in a QUAL state does not increment glitch_cnt.
- Counters:
  - event_cnt increments on each accepted rise; glitch_cnt increments on each abort.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr has priority: cnt_clr together with an increment leaves the counter at 0.
- stab_cnt is sized $clog2(STABLE_CYCLES+1) and never exceeds STABLE_CYCLES-1.
- Reset asserted mid-qualification abandons the qualification immediately; no pulse is emitted.
- X on din while en=1 is a verification error, flagged by assertion.
- Assertions:
  - !(rise_o && fall_o).
  - rise_o implies level_o rose this cycle.
  - stab_cnt < STABLE_CYCLES.

Test Plan:
- Reset, then din=1 for 4 cycles (STABLE_CYCLES=4) -> level_o=1 one cycle after the 4th sampling edge; rise_o high 1 cycle; event_cnt=1; glitch_cnt=0.
- From STABLE_LO, din=1 for 3 cycles then 0 -> level_o stays 0; no rise_o; glitch_cnt=1. Repeat 300 times with CNT_W=8 -> glitch_cnt=255 (saturated).
- level_o=1, then din=0 for 4 cycles -> fall_o for one cycle; level_o=0; event_cnt unchanged.
- en dropped after 2 high samples, din stays 1, en restored -> qualification restarts; level_o rises only after 4 new samples; glitch_cnt=0.
- event_cnt=5 with cnt_clr asserted in the same cycle as a rise -> event_cnt=0 next cycle; level_o=1 and rise_o=1 still produced.
- rst_b dropped mid-QUAL_HI with RST_VAL=1 -> level_o=1 immediately (async), counters 0, no pulses. STABLE_CYCLES=1 build: din toggling every cycle -> level_o follows din one cycle late, one pulse per toggle.
